// File: rtl/s349_divider.sv
// s349_divider -- sequential restoring divider, one quotient bit per clock.
//
// It is the inverse of the s349 shift-add multiplier and uses the same
// START/READY handshake, so the two blocks can be paired in round-trip tests.
//
// Ports:
//   CK     in   1      rising-edge clock
//   RST    in   1      asynchronous active-high reset
//   START  in   1      load A/B and begin a division (wins over everything)
//   A      in   2W     dividend, sampled only on a START edge
//   B      in   W      divisor, sampled only on a START edge
//   Q      out  W      quotient of the last completed division (registered)
//   R      out  W      remainder of the last completed division (registered)
//   READY  out  1      idle and result valid (registered)
//   OVF    out  1      last division overflowed or divided by zero (registered)
//   CNT    out  clog2(W+1)  iteration counter, for debug observability
module s349_divider #(
  parameter int W = 4
) (
  input  logic                     CK,
  input  logic                     RST,
  input  logic                     START,
  input  logic [2*W-1:0]           A,
  input  logic [W-1:0]             B,
  output logic [W-1:0]             Q,
  output logic [W-1:0]             R,
  output logic                     READY,
  output logic                     OVF,
  output logic [$clog2(W+1)-1:0]   CNT
);

  localparam int CW = $clog2(W+1);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t          state_r, state_n;
  // Partial remainder. The architectural remainder is W+1 bits, but its top
  // bit is always zero (loads are zero-extended and a non-overflow division
  // keeps rem < div), so only the low W bits are stored.
  logic [W-1:0]    rem_r, rem_n;
  logic [W-1:0]    dvd_r, dvd_n;
  logic [W-1:0]    div_r, div_n;
  logic [CW-1:0]   cnt_r, cnt_n;
  logic            ovf_pend_r, ovf_pend_n;
  logic [W-1:0]    q_r, q_n;
  logic [W-1:0]    r_r, r_n;
  logic            ovf_r, ovf_n;
  logic            ready_r, ready_n;

  logic [W:0]      t_s;
  logic [W:0]      diff_s;
  logic            qbit_s;
  logic [W-1:0]    rem_step_s;
  logic [W-1:0]    dvd_step_s;
  logic            ovf_load_s;

  // One restoring step on the current partial remainder and dividend.
  always_comb begin
    t_s        = {rem_r, dvd_r[W-1]};
    diff_s     = t_s - {1'b0, div_r};
    // With rem < div, t < 2*div, so a clear borrow bit means t >= div.
    qbit_s     = ~diff_s[W];
    if (qbit_s) begin
      rem_step_s = diff_s[W-1:0];
    end else begin
      rem_step_s = t_s[W-1:0];
    end
    dvd_step_s = {dvd_r[W-2:0], qbit_s};
    ovf_load_s = (B == {W{1'b0}}) || (A[2*W-1:W] >= B);
  end

  // Next-state and next-output logic for the IDLE/BUSY controller.
  always_comb begin
    state_n    = state_r;
    rem_n      = rem_r;
    dvd_n      = dvd_r;
    div_n      = div_r;
    cnt_n      = cnt_r;
    ovf_pend_n = ovf_pend_r;
    q_n        = q_r;
    r_n        = r_r;
    ovf_n      = ovf_r;
    ready_n    = ready_r;
    if (START) begin
      // Load (or abort and reload); the visible result is left untouched.
      state_n    = BUSY;
      ready_n    = 1'b0;
      rem_n      = A[2*W-1:W];
      dvd_n      = A[W-1:0];
      div_n      = B;
      cnt_n      = {CW{1'b0}};
      ovf_pend_n = ovf_load_s;
    end else begin
      case (state_r)
        IDLE: begin
          state_n = IDLE;
        end
        BUSY: begin
          if (ovf_pend_r) begin
            state_n    = IDLE;
            ready_n    = 1'b1;
            ovf_pend_n = 1'b0;
            q_n        = {W{1'b1}};
            r_n        = {W{1'b0}};
            ovf_n      = 1'b1;
          end else begin
            rem_n = rem_step_s;
            dvd_n = dvd_step_s;
            cnt_n = cnt_r + {{(CW-1){1'b0}}, 1'b1};
            if (cnt_r == CW'(W-1)) begin
              state_n = IDLE;
              ready_n = 1'b1;
              q_n     = dvd_step_s;
              r_n     = rem_step_s;
              ovf_n   = 1'b0;
            end else begin
              state_n = BUSY;
            end
          end
        end
        default: begin
          state_n = IDLE;
          ready_n = 1'b1;
        end
      endcase
    end
  end

  // State, datapath and output registers.
  always_ff @(posedge CK or posedge RST) begin
    if (RST) begin
      state_r    <= IDLE;
      rem_r      <= {W{1'b0}};
      dvd_r      <= {W{1'b0}};
      div_r      <= {W{1'b0}};
      cnt_r      <= {CW{1'b0}};
      ovf_pend_r <= 1'b0;
      q_r        <= {W{1'b0}};
      r_r        <= {W{1'b0}};
      ovf_r      <= 1'b0;
      ready_r    <= 1'b1;
    end else begin
      state_r    <= state_n;
      rem_r      <= rem_n;
      dvd_r      <= dvd_n;
      div_r      <= div_n;
      cnt_r      <= cnt_n;
      ovf_pend_r <= ovf_pend_n;
      q_r        <= q_n;
      r_r        <= r_n;
      ovf_r      <= ovf_n;
      ready_r    <= ready_n;
    end
  end

  assign Q     = q_r;
  assign R     = r_r;
  assign OVF   = ovf_r;
  assign READY = ready_r;
  assign CNT   = cnt_r;

endmodule

// File: tb/tb_s349_divider.sv
// tb_s349_divider -- self-checking bench for s349_divider (W=4).
// A behavioural model (integer divide with a latency countdown) is compared
// against the DUT on every falling edge; directed cases add literal checks.
module tb_s349_divider;

  localparam int W = 4;

  logic       CK    = 1'b0;
  logic       RST   = 1'b1;
  logic       START = 1'b0;
  logic [7:0] A     = 8'd0;
  logic [3:0] B     = 4'd0;
  logic [3:0] Q;
  logic [3:0] R;
  logic       READY;
  logic       OVF;
  logic [2:0] CNT;

  int checks   = 0;
  int failures = 0;

  always #5 CK = ~CK;

  s349_divider #(.W(W)) dut (
    .CK(CK), .RST(RST), .START(START), .A(A), .B(B),
    .Q(Q), .R(R), .READY(READY), .OVF(OVF), .CNT(CNT)
  );

  task automatic chk(input string nm, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp_v, $time);
    end
  endtask

  // Behavioural model: result = integer divide, appearing after a countdown.
  int m_q = 0, m_r = 0, m_ovf = 0, m_ready = 1, m_cnt = 0;
  int left = 0, pa = 0, pb = 0;
  bit povf = 1'b0;

  always @(posedge CK or posedge RST) begin
    if (RST) begin
      m_q = 0; m_r = 0; m_ovf = 0; m_ready = 1; m_cnt = 0; left = 0; povf = 1'b0;
    end else if (START) begin
      pa = int'(A);
      pb = int'(B);
      povf = (pb == 0) || ((pa / 16) >= pb);
      left = povf ? 1 : W;
      m_ready = 0;
      m_cnt = 0;
    end else if (left > 0) begin
      left--;
      if (!povf) m_cnt++;
      if (left == 0) begin
        m_ready = 1;
        if (povf) begin
          m_q = 15; m_r = 0; m_ovf = 1;
        end else begin
          m_q = pa / pb; m_r = pa % pb; m_ovf = 0;
        end
      end
    end
  end

  // Compare DUT against the model away from the active edge.
  always @(negedge CK) begin
    chk("q", int'(Q), m_q);
    chk("r", int'(R), m_r);
    chk("ovf", int'(OVF), m_ovf);
    chk("ready", int'(READY), m_ready);
    chk("cnt", int'(CNT), m_cnt);
  end

  task automatic wait_ready(input string nm, output int n);
    n = 0;
    while (!READY && n < 40) begin
      @(negedge CK);
      n++;
    end
    if (!READY) chk({nm, "_timeout"}, 0, 1);
  endtask

  task automatic do_div(input logic [7:0] a, input logic [3:0] b,
                        input int eq, input int er, input int eo, input string nm);
    int n;
    @(negedge CK);
    START = 1'b1; A = a; B = b;
    @(negedge CK);
    START = 1'b0;
    chk({nm, "_busy"}, int'(READY), 0);
    wait_ready(nm, n);
    chk({nm, "_lat"}, n, (eo != 0) ? 1 : W);
    chk({nm, "_q"}, int'(Q), eq);
    chk({nm, "_r"}, int'(R), er);
    chk({nm, "_ovf"}, int'(OVF), eo);
  endtask

  initial begin
    int n;
    logic [3:0] ra, rb;
    repeat (3) @(negedge CK);
    chk("rst_q", int'(Q), 0);
    chk("rst_ready", int'(READY), 1);
    chk("rst_cnt", int'(CNT), 0);
    RST = 1'b0;

    do_div(8'd100, 4'd7, 14, 2, 0, "norm");
    chk("norm_cnt", int'(CNT), W);
    do_div(8'hEF, 4'hF, 15, 14, 0, "bnd_max");
    do_div(8'd0, 4'd5, 0, 0, 0, "bnd_zero");
    do_div(8'd200, 4'd3, 15, 0, 1, "ovf");
    do_div(8'd17, 4'd0, 15, 0, 1, "dbz");
    do_div(8'd100, 4'd7, 14, 2, 0, "norm2");

    // Restart two cycles into a division; Q/R must not show the first one.
    @(negedge CK);
    START = 1'b1; A = 8'd100; B = 4'd7;
    @(negedge CK);
    START = 1'b0;
    @(negedge CK);
    START = 1'b1; A = 8'd45; B = 4'd6;
    @(negedge CK);
    START = 1'b0;
    chk("rst_hold_q", int'(Q), 14);
    wait_ready("restart", n);
    chk("restart_lat", n, W);
    chk("restart_q", int'(Q), 7);
    chk("restart_r", int'(R), 3);

    // Asynchronous reset in the middle of a division.
    @(negedge CK);
    START = 1'b1; A = 8'd100; B = 4'd7;
    @(negedge CK);
    START = 1'b0;
    @(negedge CK);
    #2 RST = 1'b1;
    #1;
    chk("arst_q", int'(Q), 0);
    chk("arst_r", int'(R), 0);
    chk("arst_ready", int'(READY), 1);
    chk("arst_ovf", int'(OVF), 0);
    chk("arst_cnt", int'(CNT), 0);
    #1 RST = 1'b0;
    do_div(8'd100, 4'd7, 14, 2, 0, "post_rst");

    // Round trip through a multiply: P = a*b divided by b gives back a.
    for (int i = 0; i < 40; i++) begin
      ra = 4'($urandom_range(0, 15));
      rb = 4'($urandom_range(1, 15));
      do_div(8'(int'(ra) * int'(rb)), rb, int'(ra), 0, 0, "trip");
    end

    // Random traffic including aborts and overflows, checked by the model.
    for (int i = 0; i < 1500; i++) begin
      @(negedge CK);
      START = ($urandom_range(0, 5) == 0);
      A = 8'($urandom);
      B = ($urandom_range(0, 7) == 0) ? 4'd0 : 4'($urandom);
    end
    @(negedge CK);
    START = 1'b0;
    repeat (W + 2) @(negedge CK);
    chk("final_ready", int'(READY), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
